// File: rtl/self_attention_pkg.sv
// Shared geometry for the self-attention head: element width, core tile edge and b2r slab shape.
// The b2r converter takes its defaults from here; b2r_row_t is one softmax tile (one slab row).
package self_attention_pkg;
   localparam int SA_WIDTH_OUT       = 16;
   localparam int SA_BLOCK_SIZE      = 2;
   localparam int NUM_CORES_H_B2R    = 4;
   localparam int NUM_CORES_V_B2R    = 2;
   localparam int ROW_B2R_CONVERTER  = NUM_CORES_V_B2R * SA_BLOCK_SIZE;
   localparam int COL_B2R_CONVERTER  = NUM_CORES_H_B2R * SA_BLOCK_SIZE;
   localparam int TILE_SIZE_SOFTMAX  = COL_B2R_CONVERTER;

   typedef logic [COL_B2R_CONVERTER*SA_WIDTH_OUT-1:0] b2r_row_t;
endpackage

// File: rtl/qkt_b2r_bank.sv
// One ROW x COL slab register bank: writes a whole tile at grid position (wr_h, wr_v) per cycle.
// Read is a combinational row mux; no flow control of its own, the top gates wr_en.
module qkt_b2r_bank #(
   parameter int WIDTH       = 16,
   parameter int BLOCK_SIZE  = 2,
   parameter int NUM_CORES_H = 4,
   parameter int NUM_CORES_V = 2,
   localparam int ROW = NUM_CORES_V * BLOCK_SIZE,
   localparam int COL = NUM_CORES_H * BLOCK_SIZE,
   localparam int H_W = (NUM_CORES_H > 1) ? $clog2(NUM_CORES_H) : 1,
   localparam int V_W = (NUM_CORES_V > 1) ? $clog2(NUM_CORES_V) : 1,
   localparam int R_W = (ROW > 1) ? $clog2(ROW) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 wr_en,
   input  logic [H_W-1:0]                       wr_h,
   input  logic [V_W-1:0]                       wr_v,
   input  logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH-1:0] wr_tile,
   input  logic [R_W-1:0]                       rd_idx,
   output logic [COL*WIDTH-1:0]                 rd_row
);
   localparam int SEG = BLOCK_SIZE * WIDTH;

   logic [COL*WIDTH-1:0] rows [ROW];

   for (genvar ri = 0; ri < ROW; ri++) begin : g_row
      // Slab row ri receives row (ri % BLOCK_SIZE) of tiles sitting in tile-row (ri / BLOCK_SIZE).
      localparam int TR = ri % BLOCK_SIZE;
      localparam int TV = ri / BLOCK_SIZE;
      logic [COL*WIDTH-1:0] row_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            row_q <= '0;
         end else if (wr_en && wr_v == V_W'(TV)) begin
            for (int h = 0; h < NUM_CORES_H; h++) begin
               if (wr_h == H_W'(h))
                  row_q[h*SEG +: SEG] <= wr_tile[TR*SEG +: SEG];
            end
         end
      end

      assign rows[ri] = row_q;
   end

   assign rd_row = rows[rd_idx];
endmodule

// File: rtl/qkt_b2r_converter.sv
// Reassembles QK^T core tiles into a ping-pong slab and streams it out one row per beat.
// Row valid the cycle after the final tile; in_ready low only while both banks are full.
module qkt_b2r_converter
   import self_attention_pkg::*;
#(
   parameter int WIDTH       = SA_WIDTH_OUT,
   parameter int BLOCK_SIZE  = SA_BLOCK_SIZE,
   parameter int NUM_CORES_H = NUM_CORES_H_B2R,
   parameter int NUM_CORES_V = NUM_CORES_V_B2R,
   localparam int ROW = NUM_CORES_V * BLOCK_SIZE,
   localparam int COL = NUM_CORES_H * BLOCK_SIZE,
   localparam int H_W = (NUM_CORES_H > 1) ? $clog2(NUM_CORES_H) : 1,
   localparam int V_W = (NUM_CORES_V > 1) ? $clog2(NUM_CORES_V) : 1,
   localparam int R_W = (ROW > 1) ? $clog2(ROW) : 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   flush,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH-1:0] in_tile,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [COL*WIDTH-1:0]                   out_row,
   output logic [R_W-1:0]                         out_row_idx,
   output logic                                   out_last
);
   logic           wr_bank, rd_bank;
   logic [1:0]     full;
   logic [H_W-1:0] h_cnt;
   logic [V_W-1:0] v_cnt;
   logic [R_W-1:0] row_cnt;
   logic           in_acc, out_acc, tile_last, row_last;
   logic [COL*WIDTH-1:0] bank_row [2];

   assign in_ready    = !full[wr_bank];
   assign out_valid   = full[rd_bank];
   assign in_acc      = in_valid && in_ready && !flush;
   assign out_acc     = out_valid && out_ready;
   assign tile_last   = (h_cnt == H_W'(NUM_CORES_H-1)) && (v_cnt == V_W'(NUM_CORES_V-1));
   assign row_last    = (row_cnt == R_W'(ROW-1));
   assign out_row     = bank_row[rd_bank];
   assign out_row_idx = row_cnt;
   assign out_last    = out_valid && row_last;

   // Set and clear never hit the same bank: set needs it empty, clear needs it full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         full    <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
         row_cnt <= '0;
      end else if (flush) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         full    <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
         row_cnt <= '0;
      end else begin
         if (in_acc) begin
            if (h_cnt == H_W'(NUM_CORES_H-1)) begin
               h_cnt <= '0;
               v_cnt <= tile_last ? '0 : v_cnt + V_W'(1);
            end else begin
               h_cnt <= h_cnt + H_W'(1);
            end
            if (tile_last) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= !wr_bank;
            end
         end
         if (out_acc) begin
            if (row_last) begin
               row_cnt       <= '0;
               full[rd_bank] <= 1'b0;
               rd_bank       <= !rd_bank;
            end else begin
               row_cnt <= row_cnt + R_W'(1);
            end
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      qkt_b2r_bank #(
         .WIDTH       (WIDTH),
         .BLOCK_SIZE  (BLOCK_SIZE),
         .NUM_CORES_H (NUM_CORES_H),
         .NUM_CORES_V (NUM_CORES_V)
      ) u_bank (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (in_acc && (wr_bank == 1'(b))),
         .wr_h    (h_cnt),
         .wr_v    (v_cnt),
         .wr_tile (in_tile),
         .rd_idx  (row_cnt),
         .rd_row  (bank_row[b])
      );
   end
endmodule
